// File: rtl/tuner_pkg.sv
// Shared constants for the note classifier: note codes, FSM states and the
// reference-octave period table derived from the system clock.
package tuner_pkg;

  localparam int unsigned NUM_NOTES = 7;

  localparam logic [3:0] NOTE_A    = 4'd0;
  localparam logic [3:0] NOTE_B    = 4'd1;
  localparam logic [3:0] NOTE_C    = 4'd2;
  localparam logic [3:0] NOTE_D    = 4'd3;
  localparam logic [3:0] NOTE_E    = 4'd4;
  localparam logic [3:0] NOTE_F    = 4'd5;
  localparam logic [3:0] NOTE_G    = 4'd6;
  localparam logic [3:0] NOTE_NONE = 4'hF;

  typedef enum logic [2:0] {
    StIdle,
    StMeasure,
    StFold,
    StSearch,
    StReport
  } state_e;

  // A4..G5 in millihertz
  localparam longint unsigned NOTE_MHZ [NUM_NOTES] = '{
    64'd440000, 64'd493883, 64'd523251, 64'd587330, 64'd659255, 64'd698456, 64'd783991
  };

  function automatic longint unsigned center_period(input longint unsigned clk_hz,
                                                    input int unsigned idx);
    return clk_hz * 64'd1000 / NOTE_MHZ[idx];
  endfunction

  // Half a semitone above A4: anything longer folds down an octave.
  function automatic longint unsigned p_max(input longint unsigned clk_hz);
    return center_period(clk_hz, 0) * 64'd1029 / 64'd1000;
  endfunction

  function automatic longint unsigned p_min(input longint unsigned clk_hz);
    return p_max(clk_hz) / 64'd2;
  endfunction

endpackage

// File: rtl/period_meter.sv
// Synchronizes the comparator input, detects rising edges, rejects glitches
// and counts cycles between accepted edges with saturation.
module period_meter #(
  parameter int unsigned CNT_W   = 20,
  parameter int unsigned MIN_PER = 64,
  parameter int unsigned TIMEOUT = 2**CNT_W - 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             sig_i,
  output logic             edge_o,
  output logic [CNT_W-1:0] period_o,
  output logic             timeout_o
);

  localparam logic [CNT_W-1:0] MinPer   = CNT_W'(MIN_PER);
  localparam logic [CNT_W-1:0] TimeoutC = CNT_W'(TIMEOUT);

  logic [1:0]       sync_q;
  logic             prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise;

  assign rise      = sync_q[1] & ~prev_q;
  assign edge_o    = rise && (cnt_q >= MinPer);
  assign period_o  = cnt_q;
  assign timeout_o = (cnt_q == TimeoutC);

  always_comb begin
    cnt_d = cnt_q;
    if (edge_o) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != TimeoutC) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], sig_i};
      prev_q <= sync_q[1];
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/note_classifier.sv
// Averages the input period, folds it into the A4..G5 octave and reports the
// nearest natural note with flat / sharp / in-tune flags.
module note_classifier
  import tuner_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 1_000_000,
  parameter int unsigned AVG_LOG2  = 2,
  parameter int unsigned CNT_W     = 20,
  parameter int unsigned MIN_PER   = 64,
  parameter int unsigned TIMEOUT   = 2**CNT_W - 1,
  parameter int unsigned TOL_SHIFT = 6
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       sig_i,
  output logic [3:0] note_o,
  output logic       valid_o,
  output logic       flat_o,
  output logic       sharp_o,
  output logic       in_tune_o
);

  localparam int unsigned ACC_W  = CNT_W + AVG_LOG2;
  localparam int unsigned FOLD_W = $clog2(CNT_W + 1);
  localparam logic [CNT_W-1:0] PMax = CNT_W'(p_max(64'(CLK_HZ)));
  localparam logic [CNT_W-1:0] PMin = CNT_W'(p_min(64'(CLK_HZ)));

  logic             meas_edge, meas_timeout;
  logic [CNT_W-1:0] meas_period;

  period_meter #(
    .CNT_W  (CNT_W),
    .MIN_PER(MIN_PER),
    .TIMEOUT(TIMEOUT)
  ) u_period_meter (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .sig_i    (sig_i),
    .edge_o   (meas_edge),
    .period_o (meas_period),
    .timeout_o(meas_timeout)
  );

  // Entry 7 pads the table to a power of two; the search never reaches it.
  logic [CNT_W-1:0] center_tbl [8];
  for (genvar i = 0; i < NUM_NOTES; i++) begin : g_center
    assign center_tbl[i] = CNT_W'(center_period(64'(CLK_HZ), i));
  end
  assign center_tbl[7] = '0;

  state_e              state_q;
  logic [ACC_W-1:0]    acc_q;
  logic [AVG_LOG2-1:0] idx_q;
  logic [CNT_W-1:0]    avg_q;
  logic [FOLD_W-1:0]   fold_cnt_q;
  logic [2:0]          srch_idx_q, best_idx_q;
  logic [CNT_W-1:0]    best_diff_q;

  logic [ACC_W-1:0] sum;
  logic [CNT_W-1:0] cur_center, cur_diff, best_center, tol;
  logic             fold_needed;

  assign sum         = acc_q + ACC_W'(meas_period);
  assign cur_center  = center_tbl[srch_idx_q];
  assign cur_diff    = (avg_q >= cur_center) ? avg_q - cur_center : cur_center - avg_q;
  assign best_center = center_tbl[best_idx_q];
  assign tol         = best_center >> TOL_SHIFT;
  assign fold_needed = (avg_q > PMax) || (avg_q < PMin);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      idx_q       <= '0;
      avg_q       <= '0;
      fold_cnt_q  <= '0;
      srch_idx_q  <= '0;
      best_idx_q  <= '0;
      best_diff_q <= '0;
      note_o      <= NOTE_NONE;
      valid_o     <= 1'b0;
      flat_o      <= 1'b0;
      sharp_o     <= 1'b0;
      in_tune_o   <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      // A runaway fold is treated exactly like a lost signal.
      if (meas_timeout || (state_q == StFold && fold_needed &&
                           fold_cnt_q == FOLD_W'(CNT_W))) begin
        state_q   <= StIdle;
        valid_o   <= (note_o != NOTE_NONE);
        note_o    <= NOTE_NONE;
        flat_o    <= 1'b0;
        sharp_o   <= 1'b0;
        in_tune_o <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (meas_edge) begin
              acc_q   <= '0;
              idx_q   <= '0;
              state_q <= StMeasure;
            end
          end
          StMeasure: begin
            if (meas_edge) begin
              if (idx_q == '1) begin
                avg_q      <= CNT_W'(sum >> AVG_LOG2);
                fold_cnt_q <= '0;
                state_q    <= StFold;
              end else begin
                acc_q <= sum;
                idx_q <= idx_q + 1'b1;
              end
            end
          end
          StFold: begin
            if (avg_q > PMax) begin
              avg_q      <= avg_q >> 1;
              fold_cnt_q <= fold_cnt_q + 1'b1;
            end else if (avg_q < PMin) begin
              avg_q      <= avg_q << 1;
              fold_cnt_q <= fold_cnt_q + 1'b1;
            end else begin
              srch_idx_q <= '0;
              state_q    <= StSearch;
            end
          end
          StSearch: begin
            // Strict less-than keeps the lower index on ties.
            if (srch_idx_q == 3'd0 || cur_diff < best_diff_q) begin
              best_idx_q  <= srch_idx_q;
              best_diff_q <= cur_diff;
            end
            if (srch_idx_q == 3'd6) begin
              state_q <= StReport;
            end else begin
              srch_idx_q <= srch_idx_q + 3'd1;
            end
          end
          StReport: begin
            note_o    <= {1'b0, best_idx_q};
            valid_o   <= 1'b1;
            in_tune_o <= (best_diff_q <= tol);
            flat_o    <= (best_diff_q > tol) && (avg_q > best_center);
            sharp_o   <= (best_diff_q > tol) && (avg_q < best_center);
            acc_q     <= '0;
            idx_q     <= '0;
            state_q   <= StMeasure;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_note_classifier.sv
// Drives square waves of known and random period into note_classifier and
// compares each report with an arithmetic model of the tuning rules.
module tb_note_classifier;

  localparam int unsigned TIMEOUT_TB = 6000;
  localparam longint NOTE_MHZ_TB [7] = '{
    440000, 493883, 523251, 587330, 659255, 698456, 783991
  };

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sig;
  logic [3:0] note;
  logic       valid, flat, sharp, in_tune;

  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;

  int unsigned valid_total = 0;
  logic [3:0]  rep_note = 4'hx;
  logic        rep_flat, rep_sharp, rep_tune;

  always #5 clk = ~clk;

  note_classifier #(
    .CLK_HZ   (1_000_000),
    .AVG_LOG2 (2),
    .CNT_W    (20),
    .MIN_PER  (64),
    .TIMEOUT  (TIMEOUT_TB),
    .TOL_SHIFT(6)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .sig_i    (sig),
    .note_o   (note),
    .valid_o  (valid),
    .flat_o   (flat),
    .sharp_o  (sharp),
    .in_tune_o(in_tune)
  );

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      valid_total <= valid_total + 1;
      rep_note    <= note;
      rep_flat    <= flat;
      rep_sharp   <= sharp;
      rep_tune    <= in_tune;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Nearest natural note for a steady period, straight from the tuning rules.
  task automatic model_note(input int unsigned per, output logic [3:0] n,
                            output logic f, output logic s, output logic t);
    longint c [7];
    longint pmax, pmin, avg, d, bd;
    int best;
    for (int i = 0; i < 7; i++) c[i] = 64'd1000000000 / NOTE_MHZ_TB[i];
    pmax = c[0] * 1029 / 1000;
    pmin = pmax / 2;
    avg  = per;
    while (avg > pmax) avg = avg / 2;
    while (avg < pmin) avg = avg * 2;
    best = 0;
    bd   = (avg > c[0]) ? avg - c[0] : c[0] - avg;
    for (int i = 1; i < 7; i++) begin
      d = (avg > c[i]) ? avg - c[i] : c[i] - avg;
      if (d < bd) begin
        bd   = d;
        best = i;
      end
    end
    n = 4'(best);
    t = (bd <= c[best] / 64);
    f = !t && (avg > c[best]);
    s = !t && (avg < c[best]);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_note"}, 32'(note), 32'hF);
    check_val({tag, "_valid"}, 32'(valid), 32'd0);
    check_val({tag, "_flat"}, 32'(flat), 32'd0);
    check_val({tag, "_sharp"}, 32'(sharp), 32'd0);
    check_val({tag, "_in_tune"}, 32'(in_tune), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sig   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
  endtask

  // One full period starting with a rise; the bounce adds a sub-MIN_PER re-rise.
  task automatic run_period(input int unsigned per, input bit bounce);
    int unsigned hi;
    hi  = per / 2;
    sig = 1'b1;
    if (bounce) begin
      repeat (20) @(negedge clk);
      sig = 1'b0;
      repeat (10) @(negedge clk);
      sig = 1'b1;
      repeat (hi - 30) @(negedge clk);
    end else begin
      repeat (hi) @(negedge clk);
    end
    sig = 1'b0;
    repeat (per - hi) @(negedge clk);
  endtask

  task automatic run_case(input string tag, input int unsigned per, input bit bounce);
    int unsigned start;
    logic [3:0]  en;
    logic        ef, es, et;
    start = valid_total;
    for (int p = 0; p < 4; p++) run_period(per, bounce);
    sig = 1'b1;
    repeat (60) @(negedge clk);
    model_note(per, en, ef, es, et);
    check_val({tag, "_reports"}, valid_total - start, 32'd1);
    check_val({tag, "_note"}, 32'(rep_note), 32'(en));
    check_val({tag, "_flat"}, 32'(rep_flat), 32'(ef));
    check_val({tag, "_sharp"}, 32'(rep_sharp), 32'(es));
    check_val({tag, "_in_tune"}, 32'(rep_tune), 32'(et));
  endtask

  initial begin
    int unsigned start, per;
    sig   = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (100) @(negedge clk);

    run_case("a440_bounce", 2273, 1'b1);

    // Abort mid-measurement: outputs must drop to reset values at once.
    sig = 1'b0;
    repeat (500) @(negedge clk);
    run_period(2273, 1'b0);
    run_period(2273, 1'b0);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    repeat (3) @(negedge clk);
    sig   = 1'b0;
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    per = $urandom_range(1100, 2600);
    run_case("after_reset", per, 1'b0);

    do_reset();
    run_case("g4", 2551, 1'b0);
    do_reset();
    run_case("a220", 4545, 1'b0);
    do_reset();
    run_case("a431_flat", 2320, 1'b0);

    start = valid_total;
    sig   = 1'b0;
    repeat (TIMEOUT_TB + 200) @(negedge clk);
    check_val("timeout_pulses", valid_total - start, 32'd1);
    check_val("timeout_rep_note", 32'(rep_note), 32'hF);
    check_val("timeout_note", 32'(note), 32'hF);
    check_val("timeout_flags", 32'({flat, sharp, in_tune}), 32'd0);
    check_val("timeout_rep_flags", 32'({rep_flat, rep_sharp, rep_tune}), 32'd0);

    for (int k = 0; k < 2; k++) begin
      do_reset();
      per = $urandom_range(1100, 2600);
      run_case($sformatf("rand%0d_p%0d", k, per), per, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
